// File: rtl/contador_jk_pkg.sv
// Shared constants for the contador_jk up/down counter and its bench.
// Optional feature macro: CONTADOR_JK_BCD_EN (decade counting, WIDTH must be 4).
package contador_jk_pkg;

  // Direction encodings for the 'up' input.
  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  // Default counter width in bits.
  localparam int DEFAULT_WIDTH = 4;

  // Terminal value of a decade (BCD) counter.
  localparam int BCD_MAX = 9;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-low clear.
// {j,k}: 00 hold, 01 reset, 10 set, 11 toggle.
module jk_cell (
  input  logic clk,
  input  logic clr,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK state update; clr forces 0 without waiting for a clock edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b00:   q <= q;
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/contador_jk.sv
// Up/down counter with parallel load built from one JK cell per bit.
// Priority per edge: load, then count (en), then hold.
// tc is combinational from q and up; ovf is a sticky wrap flag cleared by load or clr.
// Optional feature macro: CONTADOR_JK_BCD_EN -- decade counting (MAX = 9, WIDTH must
// be 4); a load value above 9 loads 0 and raises ovf.
// No handshake: every input is sampled on each rising clk edge, nothing is ever stalled.
module contador_jk
  import contador_jk_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic             up,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

`ifdef CONTADOR_JK_BCD_EN
  localparam logic [WIDTH-1:0] MAX = WIDTH'(BCD_MAX);
`else
  localparam logic [WIDTH-1:0] MAX = '1;
`endif

  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] wrap_val;
  logic             load_bad;
  logic             wrap_evt;
  logic             lower_ones;
  logic             lower_zeros;
  logic             ovf_q;

  // Terminal count: at MAX when counting up, at zero when counting down.
  assign tc = (up == UP) ? (q == MAX) : (q == '0);

  // A counting edge taken while at terminal count is a wrap.
  assign wrap_evt = ~load & en & tc;

  // Value the counter jumps to on a wrap.
  assign wrap_val = (up == UP) ? '0 : MAX;

`ifdef CONTADOR_JK_BCD_EN
  // Non-decimal load values are replaced by 0 and flagged through ovf.
  assign load_bad = (d > MAX);
`else
  assign load_bad = 1'b0;
`endif

  assign load_val = load_bad ? '0 : d;

  // J/K decode: load forces each bit to its target, wraps jump to wrap_val
  // explicitly (needed when MAX is not all ones), otherwise a bit toggles
  // when all lower bits are 1 (up) or all 0 (down).
  always_comb begin
    j           = '0;
    k           = '0;
    lower_ones  = 1'b1;
    lower_zeros = 1'b1;
    if (load) begin
      j = load_val;
      k = ~load_val;
    end else if (en) begin
      if (tc) begin
        j = wrap_val;
        k = ~wrap_val;
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          j[i]        = (up == UP) ? lower_ones : lower_zeros;
          k[i]        = (up == UP) ? lower_ones : lower_zeros;
          lower_ones  = lower_ones & q[i];
          lower_zeros = lower_zeros & ~q[i];
        end
      end
    end
  end

  // Sticky wrap flag: set on any wrap, cleared by load (unless the load is invalid).
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ovf_q <= 1'b0;
    end else if (load) begin
      ovf_q <= load_bad;
    end else if (wrap_evt) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;

  // One JK cell per count bit; q comes straight from the cell outputs.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .clr (clr),
      .j   (j[gi]),
      .k   (k[gi]),
      .q   (q[gi])
    );
  end

endmodule

// File: tb/tb_contador_jk.sv
// Self-checking bench for contador_jk: directed scenarios plus a randomized run
// checked against an arithmetic reference model.
// Optional feature macro: CONTADOR_JK_BCD_EN (selects the decade scenarios).
module tb_contador_jk;
  import contador_jk_pkg::*;

  localparam int W = DEFAULT_WIDTH;
`ifdef CONTADOR_JK_BCD_EN
  localparam int MAXV = BCD_MAX;
`else
  localparam int MAXV = (1 << W) - 1;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         clr;
  logic         en;
  logic         load;
  logic         up;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         tc;
  logic         ovf;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int m_q   = 0;
  bit m_ovf = 1'b0;

  always #5 clk = ~clk;

  contador_jk #(.WIDTH(W)) dut (
    .clk  (clk),
    .clr  (clr),
    .en   (en),
    .load (load),
    .up   (up),
    .d    (d),
    .q    (q),
    .tc   (tc),
    .ovf  (ovf)
  );

  // ---------------- model / driver ----------------
  // Applies the counter rules to the model using the inputs present at the edge.
  task automatic model_edge();
    if (load) begin
      if (int'(d) > MAXV) begin
        m_q   = 0;
        m_ovf = 1'b1;
      end else begin
        m_q   = int'(d);
        m_ovf = 1'b0;
      end
    end else if (en) begin
      if (up) begin
        if (m_q == MAXV) begin
          m_q   = 0;
          m_ovf = 1'b1;
        end else begin
          m_q = m_q + 1;
        end
      end else begin
        if (m_q == 0) begin
          m_q   = MAXV;
          m_ovf = 1'b1;
        end else begin
          m_q = m_q - 1;
        end
      end
    end
  endtask

  // One rising edge; returns 1 ns after it so outputs are settled.
  task automatic clock_edge();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int value);
    load = 1'b1;
    en   = 1'b0;
    d    = W'(value);
    clock_edge();
    load = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clr = 1'b0; en = 1'b0; load = 1'b0; up = DOWN; d = '0;
    #3;
    checks++;
    if (q !== '0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_init: q=%0d ovf=%0b, required q=0 ovf=0", q, ovf);
    end
    checks++;
    if (tc !== 1'b1) begin
      failures++;
      $display("FAIL reset_tc_down: tc=%0b, required 1", tc);
    end
    up = UP;
    #1;
    checks++;
    if (tc !== 1'b0) begin
      failures++;
      $display("FAIL reset_tc_up: tc=%0b, required 0", tc);
    end
    @(negedge clk);
    clr = 1'b1;
    m_q = 0; m_ovf = 1'b0;
    // count to 7, then clear between edges
    do_load(5);
    en = 1'b1; up = UP;
    clock_edge();
    clock_edge();
    checks++;
    if (q !== W'(7)) begin
      failures++;
      $display("FAIL reset_precount: q=%0d, required 7", q);
    end
    #2;
    clr = 1'b0;
    up  = DOWN;
    #1;
    m_q = 0; m_ovf = 1'b0;
    checks++;
    if (q !== '0 || ovf !== 1'b0 || tc !== 1'b1) begin
      failures++;
      $display("FAIL reset_async: q=%0d ovf=%0b tc=%0b, required q=0 ovf=0 tc=1", q, ovf, tc);
    end
    @(negedge clk);
    clr = 1'b1;
    up  = UP;
    clock_edge();
    checks++;
    if (q !== W'(1)) begin
      failures++;
      $display("FAIL reset_resume: q=%0d, required 1", q);
    end
    en = 1'b0;
  endtask

`ifndef CONTADOR_JK_BCD_EN
  task automatic test_up_wrap();
    do_load(14);
    en = 1'b1; up = UP;
    clock_edge();
    checks++;
    if (q !== W'(15) || tc !== 1'b1 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL up_wrap_15: q=%0d tc=%0b ovf=%0b, required q=15 tc=1 ovf=0", q, tc, ovf);
    end
    clock_edge();
    checks++;
    if (q !== W'(0) || ovf !== 1'b1) begin
      failures++;
      $display("FAIL up_wrap_0: q=%0d ovf=%0b, required q=0 ovf=1", q, ovf);
    end
    clock_edge();
    checks++;
    if (q !== W'(1) || ovf !== 1'b1) begin
      failures++;
      $display("FAIL up_wrap_1: q=%0d ovf=%0b, required q=1 ovf=1", q, ovf);
    end
    en = 1'b0;
  endtask

  task automatic test_down_wrap();
    do_load(1);
    en = 1'b1; up = DOWN;
    clock_edge();
    checks++;
    if (q !== W'(0) || tc !== 1'b1 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL down_wrap_0: q=%0d tc=%0b ovf=%0b, required q=0 tc=1 ovf=0", q, tc, ovf);
    end
    clock_edge();
    checks++;
    if (q !== W'(15) || ovf !== 1'b1) begin
      failures++;
      $display("FAIL down_wrap_15: q=%0d ovf=%0b, required q=15 ovf=1", q, ovf);
    end
    en = 1'b0;
  endtask

  task automatic test_load_priority();
    do_load(15);
    up = UP; en = 1'b1; load = 1'b1; d = W'(5);
    #1;
    checks++;
    if (tc !== 1'b1) begin
      failures++;
      $display("FAIL load_prio_tc: tc=%0b, required 1", tc);
    end
    clock_edge();
    checks++;
    if (q !== W'(5) || ovf !== 1'b0) begin
      failures++;
      $display("FAIL load_prio: q=%0d ovf=%0b, required q=5 ovf=0", q, ovf);
    end
    load = 1'b0; en = 1'b0;
  endtask
`endif

  task automatic test_hold();
    do_load(9);
    en = 1'b0; load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      up = 1'($urandom_range(0, 1));
      d  = W'($urandom);
      clock_edge();
      checks++;
      if (q !== W'(9) || ovf !== 1'b0) begin
        failures++;
        $display("FAIL hold_%0d: q=%0d ovf=%0b, required q=9 ovf=0", i, q, ovf);
      end
    end
  endtask

`ifdef CONTADOR_JK_BCD_EN
  task automatic test_bcd();
    do_load(8);
    en = 1'b1; up = UP;
    clock_edge();
    checks++;
    if (q !== W'(9) || tc !== 1'b1 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL bcd_up_9: q=%0d tc=%0b ovf=%0b, required q=9 tc=1 ovf=0", q, tc, ovf);
    end
    clock_edge();
    checks++;
    if (q !== W'(0) || ovf !== 1'b1) begin
      failures++;
      $display("FAIL bcd_up_wrap: q=%0d ovf=%0b, required q=0 ovf=1", q, ovf);
    end
    do_load(0);
    en = 1'b1; up = DOWN;
    clock_edge();
    checks++;
    if (q !== W'(9) || ovf !== 1'b1) begin
      failures++;
      $display("FAIL bcd_down_wrap: q=%0d ovf=%0b, required q=9 ovf=1", q, ovf);
    end
    en = 1'b0;
    do_load(12);
    checks++;
    if (q !== W'(0) || ovf !== 1'b1) begin
      failures++;
      $display("FAIL bcd_bad_load: q=%0d ovf=%0b, required q=0 ovf=1", q, ovf);
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      en   = 1'($urandom_range(0, 3) != 0);
      load = 1'($urandom_range(0, 9) == 0);
      up   = 1'($urandom_range(0, 1));
      d    = W'($urandom);
      #1;
      checks++;
      if (tc !== ((up ? (m_q == MAXV) : (m_q == 0)) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL rand_tc_%0d: tc=%0b up=%0b model_q=%0d", n, tc, up, m_q);
      end
      if ($urandom_range(0, 49) == 0) begin
        clr = 1'b0;
        #1;
        m_q = 0; m_ovf = 1'b0;
        checks++;
        if (q !== '0 || ovf !== 1'b0) begin
          failures++;
          $display("FAIL rand_clr_%0d: q=%0d ovf=%0b, required q=0 ovf=0", n, q, ovf);
        end
        clr = 1'b1;
      end
      clock_edge();
      checks++;
      if (q !== m_q[W-1:0] || ovf !== m_ovf) begin
        failures++;
        $display("FAIL rand_step_%0d: q=%0d ovf=%0b, required q=%0d ovf=%0b",
                 n, q, ovf, m_q, m_ovf);
      end
    end
    en = 1'b0; load = 1'b0;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
`ifndef CONTADOR_JK_BCD_EN
    test_up_wrap();
    test_down_wrap();
    test_load_priority();
`else
    test_bcd();
`endif
    test_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion before 200000");
    $fatal(1);
  end

endmodule

// File: doc/contador_jk.md
CONTADOR_JK -- requirements
Module: contador_jk

Interface
REQ-001 SHALL have parameter WIDTH, default 4, which sets the counter width in bits (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port clr, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port en, input, 1 bit: count enable.
REQ-005 SHALL have port load, input, 1 bit: synchronous parallel load.
REQ-006 SHALL have port up, input, 1 bit: direction, 1 = increment, 0 = decrement.
REQ-007 SHALL have port d, input, WIDTH bits: parallel load value.
REQ-008 SHALL have port q, output, WIDTH bits: count value, taken directly from the JK cell outputs.
REQ-009 SHALL have port tc, output, 1 bit: terminal count, combinational.
REQ-010 SHALL have port ovf, output, 1 bit: sticky wrap flag, registered.

Function
REQ-011 SHALL define MAX as 2^WIDTH-1, or as 9 when the BCD option (REQ-024) is compiled in.
REQ-012 SHALL apply this priority at each rising clk edge: load, then en, then hold.
REQ-013 SHALL, when load=1, set q to d and clear ovf; the load takes effect on the next edge with 1-cycle latency.
REQ-014 SHALL, when load=0, en=1 and up=1, set q to q+1, wrapping MAX to 0.
REQ-015 SHALL, when load=0, en=1 and up=0, set q to q-1, wrapping 0 to MAX.
REQ-016 SHALL set ovf to 1 on any wrap (REQ-014/015); ovf stays 1 until load or clr.
REQ-017 SHALL drive tc = (up & q==MAX) | (~up & q==0), independent of en.
REQ-018 SHALL give load priority over a wrap on the same edge: q=d and ovf=0.
REQ-019 SHALL let an up change between edges affect only the next count step and tc; q SHALL NOT glitch.
REQ-020 SHALL hold q and ovf while en=0 and load=0.
REQ-021 SHALL implement each q bit as one JK cell:
- counting: j=k=toggle condition for that bit (all lower bits 1 when counting up, all lower bits 0 when counting down; wrap handled explicitly where MAX < 2^WIDTH-1);
- load: j=d[i], k=~d[i];
- hold: j=k=0.

Reset
REQ-022 SHALL, while clr=0, force q=0 and ovf=0 immediately, independent of clk, so tc = ~up.
REQ-023 SHALL abort any count or load in progress on clr assertion, and SHALL resume normal operation at the first rising clk edge after clr returns to 1.

Configuration
REQ-024 SHALL, when macro CONTADOR_JK_BCD_EN is defined, require WIDTH=4 and set MAX=9:
- up from 9 wraps to 0; down from 0 wraps to 9;
- a load with d>9 loads 0 and sets ovf=1.
REQ-025 SHALL, without CONTADOR_JK_BCD_EN, use MAX=2^WIDTH-1 and accept every d value unchanged.

Structure
REQ-026 SHALL place the shared constants (direction encodings UP/DOWN, default WIDTH, BCD MAX value 9) in shared package contador_jk_pkg, included by the RTL and by the bench.
REQ-027 SHALL use exactly one sub-module, jk_cell, with ports j, k, clk, clr and q:
- per edge: 00 hold, 01 reset, 10 set, 11 toggle;
- asynchronous active-low clr.
REQ-028 SHALL instantiate jk_cell WIDTH times via generate; the next-state logic SHALL contain only j/k decode, wrap detection and ovf.

Verification
REQ-029 SHALL cover reset: clr=0 mid-count with q=7 -> q=0 and ovf=0 with no clk edge; tc=1 when up=0.
REQ-030 SHALL cover up-count wrap (WIDTH=4): load 14, then en=1, up=1 for 3 edges -> q=15 (tc=1), 0, 1; ovf=1 from the edge where q becomes 0.
REQ-031 SHALL cover down-count wrap: load 1, then en=1, up=0 for 2 edges -> q=0 (tc=1), 15; ovf=1.
REQ-032 SHALL cover load priority: q=15, up=1, en=1, load=1 with d=5 -> q=5 and ovf=0 (no wrap recorded).
REQ-033 SHALL cover hold: en=0, load=0 for 4 edges at q=9 -> q stays 9 and ovf unchanged.
REQ-034 SHALL cover the BCD option (with CONTADOR_JK_BCD_EN defined):
- count up from 8 -> 9, 0; ovf=1;
- load d=12 -> q=0 and ovf=1.
